// File: rtl/mips_pkg.sv
// Shared definitions for the memory-port arbiter: default parameters and FSM state encoding.
package mips_pkg;

    localparam int DEF_N       = 64;
    localparam int DEF_AW      = 32;
    localparam int DEF_STARVE  = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } arb_state_t;

    function automatic logic is_busy(input arb_state_t s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access, with data priority,
// bounded instruction starvation and a BUSY-cycle timeout that raises a sticky bus error.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int AW      = DEF_AW,
    parameter int STARVE  = DEF_STARVE,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instrreq,
    input  logic [AW-1:0]     instradr,
    output logic [31:0]       instr,
    output logic              instrabort,
    input  logic              datareq,
    input  logic [AW-1:0]     dataadr,
    input  logic              datawe,
    input  logic [N/8-1:0]    databe,
    input  logic [N-1:0]      writedata,
    output logic [N-1:0]      readdata,
    output logic              dataabort,
    output logic              mreq,
    output logic [AW-1:0]     maddr,
    output logic              mwe,
    output logic [N/8-1:0]    mbe,
    output logic [N-1:0]      mwdata,
    input  logic              mready,
    input  logic [N-1:0]      mrdata,
    output logic              buserr
);

    localparam int SW = $clog2(STARVE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    arb_state_t    state, state_next;
    logic          grant_i, grant_d, timed_out;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] busy_cnt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (datareq && (starve_cnt < STARVE_MAX)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (instrreq) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // A completing mready wins over a timeout landing in the same cycle.
                if (mready) begin
                    state_next = (state == BUSY_I) ? DONE_I : DONE_D;
                end else if (busy_cnt == TIMEOUT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = (state == BUSY_I) ? DONE_I : DONE_D;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign instrabort = instrreq & (state != DONE_I);
    assign dataabort  = datareq  & (state != DONE_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mreq       <= 1'b0;
            maddr      <= '0;
            mwe        <= 1'b0;
            mbe        <= '0;
            mwdata     <= '0;
            instr      <= '0;
            readdata   <= '0;
            buserr     <= 1'b0;
            starve_cnt <= '0;
            busy_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values.
            state    <= state_next;
            mreq     <= is_busy(state_next);
            busy_cnt <= (is_busy(state) && is_busy(state_next)) ? busy_cnt + 1'b1 : '0;

            if (grant_d) begin
                maddr  <= dataadr;
                mwe    <= datawe;
                mbe    <= databe;
                mwdata <= writedata;
            end else if (grant_i) begin
                maddr  <= instradr;
                mwe    <= 1'b0;
                mbe    <= '1;
                mwdata <= '0;
            end

            if (state == BUSY_I) begin
                if (mready)         instr <= mrdata[31:0];
                else if (timed_out) instr <= '0;
            end
            if (state == BUSY_D) begin
                if (mready && !mwe) readdata <= mrdata;
                else if (timed_out) readdata <= '0;
            end
            if (timed_out) buserr <= 1'b1;

            // Counts data grants that overtook a waiting fetch; reaching STARVE forces the fetch through.
            if (grant_i || !instrreq) begin
                starve_cnt <= '0;
            end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
